// File: rtl/pic_port_link.sv
// Receive link from the PIC32 parallel port: pin synchronisers, 4-phase strobe/ack byte
// handshake, word assembly and a DEPTH-entry FIFO drained over valid/ready to the core.
//
// state    | meaning
// WAIT_LOW | after reset, wait for the strobe to go low before accepting bytes
// IDLE     | waiting for the MCU strobe to rise
// LATCH    | capture the byte; push the word when it is complete
// STALL    | word complete but FIFO full; hold it until a slot frees
// ACK      | port_ack high until the MCU drops the strobe
module pic_port_link #(
    parameter int WORD_BYTES    = 4,
    parameter int DEPTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [7:0]                   port_data,
    input  logic                         port_strobe,
    input  logic                         port_start,
    output logic                         port_ack,
    output logic                         port_busy,
    output logic                         port_error,
    input  logic                         err_clear,
    output logic [WORD_BYTES*8-1:0]      out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);

    typedef enum logic [2:0] {WAIT_LOW, IDLE, LATCH, STALL, ACK} state_t;

    logic [SYNC_STAGES-1:0]      strobe_sync_q, strobe_sync_d;
    logic [SYNC_STAGES-1:0]      start_sync_q, start_sync_d;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]           word_q, word_d;
    logic [WORD_W-1:0]           mem_q [DEPTH];
    logic [WORD_W-1:0]           mem_d [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        port_ack_q, port_ack_d;
    logic                        port_busy_q, port_busy_d;
    logic                        port_error_q, port_error_d;

    logic                        strobe_s, start_s;
    logic [7:0]                  data_s;
    logic                        pop, push, can_accept, frame_err;
    logic [CNT_W-1:0]            base_cnt, next_cnt;
    int                          pos;

    assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
    assign start_s  = start_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign port_ack   = port_ack_q;
    assign port_busy  = port_busy_q;
    assign port_error = port_error_q;

    assign pop        = out_valid && out_ready;
    assign can_accept = (level_q != LVL_FULL) || pop;

    always_comb begin
        strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], port_strobe};
        start_sync_d  = {start_sync_q[SYNC_STAGES-2:0], port_start};
        data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], port_data};
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        push       = 1'b0;
        frame_err  = 1'b0;
        base_cnt   = byte_cnt_q;
        next_cnt   = byte_cnt_q;
        pos        = 0;
        case (state_q)
            WAIT_LOW: if (!strobe_s) state_d = IDLE;
            IDLE:     if (strobe_s) state_d = LATCH;
            LATCH: begin
                // A start marker inside a word drops the partial word and restarts at byte 0.
                if (start_s && (byte_cnt_q != '0)) begin
                    frame_err = 1'b1;
                    base_cnt  = '0;
                    word_d    = '0;
                end
                if (LITTLE_ENDIAN != 0) pos = int'(base_cnt);
                else                    pos = WORD_BYTES - 1 - int'(base_cnt);
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (i == pos) word_d[i*8 +: 8] = data_s;
                end
                next_cnt = base_cnt + CNT_ONE;
                if (next_cnt == CNT_FULL) begin
                    if (can_accept) begin
                        push       = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = ACK;
                    end else begin
                        byte_cnt_d = next_cnt;
                        state_d    = STALL;
                    end
                end else begin
                    byte_cnt_d = next_cnt;
                    state_d    = ACK;
                end
            end
            STALL: begin
                if (can_accept) begin
                    push       = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ACK;
                end
            end
            ACK:      if (!strobe_s) state_d = IDLE;
            default:  state_d = WAIT_LOW;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = word_d;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
    end

    always_comb begin
        port_ack_d   = (state_d == ACK);
        port_busy_d  = (level_d == LVL_FULL) || (state_d == STALL);
        port_error_d = port_error_q;
        if (err_clear) port_error_d = 1'b0;
        if (frame_err) port_error_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            strobe_sync_q <= '1;
            start_sync_q  <= '0;
            data_sync_q   <= '0;
            state_q       <= WAIT_LOW;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            port_ack_q    <= 1'b0;
            port_busy_q   <= 1'b0;
            port_error_q  <= 1'b0;
        end else begin
            strobe_sync_q <= strobe_sync_d;
            start_sync_q  <= start_sync_d;
            data_sync_q   <= data_sync_d;
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            port_ack_q    <= port_ack_d;
            port_busy_q   <= port_busy_d;
            port_error_q  <= port_error_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pic_port_link.sv
// Directed bench for pic_port_link: a little-endian and a big-endian instance share the
// MCU-side stimulus; every expected value below is hand-derived.
module tb_pic_port_link;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  port_data;
    logic        port_strobe;
    logic        port_start;
    logic        err_clear;
    logic        out_ready;

    logic        port_ack, port_busy, port_error, out_valid;
    logic [31:0] out_data;
    logic [3:0]  fifo_level;

    logic        ack_be, busy_be, error_be, valid_be;
    logic [31:0] out_data_be;
    logic [3:0]  level_be;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pic_port_link #(.WORD_BYTES(4), .DEPTH(8), .SYNC_STAGES(2), .LITTLE_ENDIAN(1)) dut_le (
        .clock(clock), .reset_n(reset_n), .port_data(port_data), .port_strobe(port_strobe),
        .port_start(port_start), .port_ack(port_ack), .port_busy(port_busy),
        .port_error(port_error), .err_clear(err_clear), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level)
    );

    pic_port_link #(.WORD_BYTES(4), .DEPTH(8), .SYNC_STAGES(2), .LITTLE_ENDIAN(0)) dut_be (
        .clock(clock), .reset_n(reset_n), .port_data(port_data), .port_strobe(port_strobe),
        .port_start(port_start), .port_ack(ack_be), .port_busy(busy_be),
        .port_error(error_be), .err_clear(err_clear), .out_data(out_data_be),
        .out_valid(valid_be), .out_ready(out_ready), .fifo_level(level_be)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full handshake for one byte; ack must rise 4 edges after strobe is first sampled high.
    task automatic send_byte(input logic [7:0] d, input logic st);
        int n;
        @(negedge clock);
        port_data  = d;
        port_start = st;
        @(negedge clock);
        port_strobe = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            n++;
            #1;
            if (port_ack) break;
        end
        check("ack_lat", 64'(n), 64'd4);
        @(negedge clock);
        port_strobe = 1'b0;
        n = 0;
        while (port_ack && n < 40) begin
            @(posedge clock);
            n++;
            #1;
        end
        check("ack_drop", 64'(port_ack), 64'd0);
    endtask

    function automatic logic [31:0] word_le(input int i);
        logic [7:0] b;
        b = 8'(i * 16);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        port_data   = 8'h00;
        port_strobe = 1'b0;
        port_start  = 1'b0;
        err_clear   = 1'b0;
        out_ready   = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_ack",   64'(port_ack),   64'd0);
        check("rst_busy",  64'(port_busy),  64'd0);
        check("rst_error", 64'(port_error), 64'd0);
        check("rst_valid", 64'(out_valid),  64'd0);
        check("rst_data",  64'(out_data),   64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Basic word, both byte orders
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("le_data",  64'(out_data),    64'h44332211);
        check("be_data",  64'(out_data_be), 64'h11223344);
        check("w1_valid", 64'(out_valid),   64'd1);
        check("w1_level", 64'(fifo_level),  64'd1);

        // Pop, then ready while empty must do nothing
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        check("pop_level", 64'(fifo_level), 64'd0);
        check("pop_valid", 64'(out_valid),  64'd0);
        repeat (3) @(negedge clock);
        check("empty_ready_level", 64'(fifo_level), 64'd0);
        check("empty_ready_data",  64'(out_data),   64'd0);
        out_ready = 1'b0;

        // Framing error: start inside a word restarts the word
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        check("no_err_yet", 64'(port_error), 64'd0);
        send_byte(8'hCC, 1'b1);
        check("frame_err", 64'(port_error), 64'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("frame_le", 64'(out_data),    64'h030201CC);
        check("frame_be", 64'(out_data_be), 64'hCC010203);
        check("frame_level", 64'(fifo_level), 64'd1);
        check("err_sticky", 64'(port_error), 64'd1);

        @(negedge clock);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        check("err_clear_alone", 64'(port_error), 64'd0);

        // Error set coincident with err_clear: set wins
        send_byte(8'hA0, 1'b1);
        @(negedge clock);
        port_data  = 8'hCC;
        port_start = 1'b1;
        @(negedge clock);
        port_strobe = 1'b1;
        repeat (3) @(posedge clock);
        #1 err_clear = 1'b1;
        @(posedge clock);
        #1 err_clear = 1'b0;
        check("set_wins_ack",   64'(port_ack),   64'd1);
        check("set_wins_error", 64'(port_error), 64'd1);
        @(negedge clock);
        port_strobe = 1'b0;
        repeat (6) @(negedge clock);

        // Reset mid-word with strobe held high
        @(negedge clock);
        port_data  = 8'h55;
        port_start = 1'b0;
        @(negedge clock);
        port_strobe = 1'b1;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_rst_ack",   64'(port_ack),   64'd0);
        check("mid_rst_busy",  64'(port_busy),  64'd0);
        check("mid_rst_error", 64'(port_error), 64'd0);
        check("mid_rst_valid", 64'(out_valid),  64'd0);
        check("mid_rst_data",  64'(out_data),   64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("held_strobe_ack",   64'(port_ack),   64'd0);
        check("held_strobe_level", 64'(fifo_level), 64'd0);
        port_strobe = 1'b0;
        repeat (6) @(negedge clock);
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b0);
        check("post_rst_le",    64'(out_data),    64'h64636261);
        check("post_rst_be",    64'(out_data_be), 64'h61626364);
        check("post_rst_level", 64'(fifo_level),  64'd1);
        check("post_rst_error", 64'(port_error),  64'd0);
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("drain_level", 64'(fifo_level), 64'd0);

        // Fill the FIFO, then stall the ninth word
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(w * 16 + b), (b == 0));
        end
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_busy",  64'(port_busy),  64'd1);
        check("full_head",  64'(out_data),   64'(word_le(0)));
        for (int b = 0; b < 3; b++) send_byte(8'(8 * 16 + b), (b == 0));
        @(negedge clock);
        port_data  = 8'h83;
        port_start = 1'b0;
        @(negedge clock);
        port_strobe = 1'b1;
        repeat (10) @(negedge clock);
        check("stall_ack",   64'(port_ack),   64'd0);
        check("stall_busy",  64'(port_busy),  64'd1);
        check("stall_level", 64'(fifo_level), 64'd8);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("unstall_ack",   64'(port_ack),   64'd1);
        check("unstall_level", 64'(fifo_level), 64'd8);
        check("unstall_head",  64'(out_data),   64'(word_le(1)));
        check("unstall_busy",  64'(port_busy),  64'd1);
        @(negedge clock);
        port_strobe = 1'b0;
        n = 0;
        while (port_ack && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("unstall_drop", 64'(port_ack), 64'd0);

        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain_w%0d", k), 64'(out_data), 64'(word_le(k)));
            out_ready = 1'b1;
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("final_level", 64'(fifo_level), 64'd0);
        check("final_valid", 64'(out_valid),  64'd0);
        check("final_busy",  64'(port_busy),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
